// File: rtl/add_chunk_sequencer_pkg.sv
// rtl/add_chunk_sequencer_pkg.sv - shared FSM encoding and counter width helper
package add_chunk_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_b.sv
// rtl/adder_b.sv - (n_bit+1)-bit carry-lookahead adder, no carry-out port
module adder_b #(
  parameter int n_bit = 15
) (
  input  logic [n_bit:0] a,
  input  logic [n_bit:0] b,
  input  logic           cin,
  output logic [n_bit:0] s
);

  logic [n_bit:0] w_g;
  logic [n_bit:0] w_p;
  logic [n_bit:0] w_c;
  logic           w_pp;
  logic           w_ci;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a flat sum of products over all lower generate/propagate terms.
  always_comb begin
    w_c  = '0;
    w_pp = 1'b1;
    w_ci = 1'b0;
    for (int i = 0; i <= n_bit; i++) begin
      w_ci = 1'b0;
      w_pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        w_ci = w_ci | (w_pp & w_g[j]);
        w_pp = w_pp & w_p[j];
      end
      w_c[i] = w_ci | (w_pp & cin);
    end
  end

  assign s = w_p ^ w_c;

endmodule

// File: rtl/add_chunk_sequencer.sv
// rtl/add_chunk_sequencer.sv - multi-cycle wide add/sub, one CHUNK_W chunk per cycle LSB-first
module add_chunk_sequencer
  import add_chunk_sequencer_pkg::*;
#(
  parameter int CHUNK_W  = 16,
  parameter int N_CHUNKS = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CHUNK_W*N_CHUNKS-1:0]   req_a,
  input  logic [CHUNK_W*N_CHUNKS-1:0]   req_b,
  input  logic                          req_sub,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CHUNK_W*N_CHUNKS-1:0]   rsp_sum,
  output logic                          rsp_cout,
  output logic                          rsp_ovf,
  output logic                          busy
);

  localparam int W  = CHUNK_W * N_CHUNKS;
  localparam int CW = cnt_w(N_CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(N_CHUNKS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_carry;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_bx;
  logic [W-1:0]        r_sum;
  logic                r_cout;
  logic                r_ovf;

  logic [CHUNK_W-1:0]  w_a_ch;
  logic [CHUNK_W-1:0]  w_b_ch;
  logic [CHUNK_W-1:0]  w_s_ch;
  logic                w_a_m;
  logic                w_b_m;
  logic                w_s_m;
  logic                w_cout_ch;
  logic                w_last;

  assign w_a_ch = r_a[r_cnt*CHUNK_W +: CHUNK_W];
  assign w_b_ch = r_bx[r_cnt*CHUNK_W +: CHUNK_W];

  adder_b #(.n_bit(CHUNK_W - 1)) u_chunk_add (
    .a   (w_a_ch),
    .b   (w_b_ch),
    .cin (r_carry),
    .s   (w_s_ch)
  );

  // Carry-out recovered from the MSB operands and sum since adder_b exposes none.
  assign w_a_m     = w_a_ch[CHUNK_W-1];
  assign w_b_m     = w_b_ch[CHUNK_W-1];
  assign w_s_m     = w_s_ch[CHUNK_W-1];
  assign w_cout_ch = (w_a_m & w_b_m) | ((w_a_m | w_b_m) & ~w_s_m);
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_bx    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_a     <= req_a;
      r_bx    <= req_b ^ {W{req_sub}};
      r_carry <= req_sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[r_cnt*CHUNK_W +: CHUNK_W] <= w_s_ch;
      r_carry <= w_cout_ch;
      if (w_last) begin
        r_cout <= w_cout_ch;
        r_ovf  <= (w_s_m ^ w_a_m ^ w_b_m) ^ w_cout_ch;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_add_chunk_sequencer.sv
// tb/tb_add_chunk_sequencer.sv - directed and random checks of add_chunk_sequencer against a reference model
module tb_add_chunk_sequencer;

  localparam int NC = 4;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          req_sub = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout;
  logic          rsp_ovf;
  logic          busy;

  logic          n_req_valid = 1'b0;
  logic          n_req_ready;
  logic [15:0]   n_req_a = '0;
  logic [15:0]   n_req_b = '0;
  logic          n_req_sub = 1'b0;
  logic          n_rsp_valid;
  logic          n_rsp_ready = 1'b0;
  logic [15:0]   n_rsp_sum;
  logic          n_rsp_cout;
  logic          n_rsp_ovf;
  logic          n_busy;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_sum;
  logic          exp_cout;
  logic          exp_ovf;

  always #5 clk = ~clk;

  add_chunk_sequencer #(.CHUNK_W(16), .N_CHUNKS(NC)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .busy(busy)
  );

  add_chunk_sequencer #(.CHUNK_W(16), .N_CHUNKS(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_a(n_req_a), .req_b(n_req_b), .req_sub(n_req_sub), .rsp_valid(n_rsp_valid),
    .rsp_ready(n_rsp_ready), .rsp_sum(n_rsp_sum), .rsp_cout(n_rsp_cout),
    .rsp_ovf(n_rsp_ovf), .busy(n_busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word arithmetic: unsigned carry from a 65-bit sum, no-borrow as a>=b, overflow from signs.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] wide;
    if (!sub) begin
      wide     = {1'b0, a} + {1'b0, b};
      exp_sum  = wide[W-1:0];
      exp_cout = wide[W];
      exp_ovf  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
    end else begin
      exp_sum  = a - b;
      exp_cout = (a >= b);
      exp_ovf  = (a[W-1] != b[W-1]) && (exp_sum[W-1] != a[W-1]);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    chk("req_ready_before_accept", req_ready, 1);
    model(a, b, sub);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_result(input string tag);
    int cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (rsp_valid) break;
    end
    chk({tag, "_latency"}, cyc, NC);
    chk({tag, "_sum"}, rsp_sum, exp_sum);
    chk({tag, "_cout"}, rsp_cout, exp_cout);
    chk({tag, "_ovf"}, rsp_ovf, exp_ovf);
    chk({tag, "_ready_low"}, req_ready, 0);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid, 0);
    chk({tag, "_idle_ready"}, req_ready, 1);
    chk({tag, "_held_sum"}, rsp_sum, exp_sum);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_ovf", rsp_ovf, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_n1_ready", n_req_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_result("t1");
    chk("t1_lit_sum", rsp_sum, 64'h0000_0000_0001_0000);
    handshake("t1");

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_result("t2a");
    chk("t2a_lit_sum", rsp_sum, 64'h0);
    chk("t2a_lit_cout", rsp_cout, 1);
    handshake("t2a");

    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_result("t2b");
    chk("t2b_lit_sum", rsp_sum, 64'h8000_0000_0000_0000);
    chk("t2b_lit_ovf", rsp_ovf, 1);
    handshake("t2b");

    send(64'h0, 64'h1, 1'b1);
    wait_result("t3a");
    chk("t3a_lit_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3a_lit_cout", rsp_cout, 0);
    handshake("t3a");

    send(64'h5, 64'h3, 1'b1);
    wait_result("t3b");
    chk("t3b_lit_sum", rsp_sum, 64'h2);
    chk("t3b_lit_cout", rsp_cout, 1);
    handshake("t3b");

    // Backpressure with a new request held during DONE
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    wait_result("t4a");
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    req_a = ra; req_b = rb; req_sub = 1'b1; req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("t4_stall_valid", rsp_valid, 1);
      chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_sum", rsp_sum, exp_sum);
      chk("t4_stall_cout", rsp_cout, exp_cout);
    end
    handshake("t4a");
    model(ra, rb, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t4_held_accept", busy, 1);
    wait_result("t4b");
    handshake("t4b");

    // Reset mid-RUN at chunk 2
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_running", busy, 1);
    rstn = 1'b0;
    #1;
    chk("t5_sum", rsp_sum, 0);
    chk("t5_cout", rsp_cout, 0);
    chk("t5_ovf", rsp_ovf, 0);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("t5_ready", req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("t5_no_result", rsp_valid, 0);
    end
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    wait_result("t5_after");
    handshake("t5_after");

    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      if (n % 6 == 0) rb = ~ra;
      if (n % 6 == 1) rb = ra;
      send(ra, rb, rs);
      wait_result("rnd");
      handshake("rnd");
    end

    // Single-chunk instance
    @(negedge clk);
    n_req_a = 16'hFFFF; n_req_b = 16'h0001; n_req_sub = 1'b0; n_req_valid = 1'b1;
    chk("t6_ready", n_req_ready, 1);
    @(posedge clk);
    #1;
    n_req_valid = 1'b0;
    chk("t6_not_yet", n_rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("t6_valid", n_rsp_valid, 1);
    chk("t6_sum", n_rsp_sum, 0);
    chk("t6_cout", n_rsp_cout, 1);
    chk("t6_ovf", n_rsp_ovf, 0);
    n_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_rsp_ready = 1'b0;
    chk("t6_idle", n_req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
